// File: rtl/word_unpacker.sv
// Word-to-byte unpacker: buffers 16-bit words in a circular FIFO and streams them out high byte first.
// Optional sticky overflow flag enabled by defining WORD_UNPACKER_OVF_EN.
module word_unpacker #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [15:0]              wr_data,
    output logic                     wr_full,
    output logic [$clog2(DEPTH):0]   level,
    output logic [7:0]               byte_out,
    output logic                     byte_valid,
    input  logic                     rd_ready,
    output logic                     ovf
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        HI,
        LO
    } state_t;

    logic [15:0]   mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [15:0]   hold;
    state_t        state;
    state_t        state_nxt;
    logic          push;
    logic          pop;
    logic          nonempty;

    assign wr_full  = (level == FULL_LEVEL);
    assign nonempty = (level != '0);
    // A full buffer refuses the write even if the serializer pops on the same edge.
    assign push     = wr_en && !wr_full;

    always_comb begin
        state_nxt  = state;
        pop        = 1'b0;
        byte_valid = 1'b0;
        byte_out   = 8'h00;
        case (state)
            IDLE: begin
                if (nonempty) begin
                    pop       = 1'b1;
                    state_nxt = HI;
                end
            end
            HI: begin
                byte_valid = 1'b1;
                byte_out   = hold[15:8];
                if (rd_ready) state_nxt = LO;
            end
            LO: begin
                byte_valid = 1'b1;
                byte_out   = hold[7:0];
                if (rd_ready) begin
                    if (nonempty) begin
                        pop       = 1'b1;
                        state_nxt = HI;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
            hold  <= '0;
        end else begin
            state <= state_nxt;
            if (push) wptr <= wptr + AW'(1);
            if (pop) begin
                rptr <= rptr + AW'(1);
                hold <= mem[rptr];
            end
            case ({push, pop})
                2'b10:   level <= level + (AW+1)'(1);
                2'b01:   level <= level - (AW+1)'(1);
                default: level <= level;
            endcase
        end
    end

`ifdef WORD_UNPACKER_OVF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ovf <= 1'b0;
        else if (wr_en && wr_full) ovf <= 1'b1;
    end
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_word_unpacker.sv
// Bench for word_unpacker: directed vector table, hand-written corner sequences and
// randomized traffic compared against a queue-based reference model.
module tb_word_unpacker;

    localparam int DEPTH = 4;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   wr_en = 1'b0;
    logic [15:0]            wr_data = '0;
    logic                   wr_full;
    logic [$clog2(DEPTH):0] level;
    logic [7:0]             byte_out;
    logic                   byte_valid;
    logic                   rd_ready = 1'b0;
    logic                   ovf;

    word_unpacker #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data),
        .wr_full(wr_full), .level(level), .byte_out(byte_out),
        .byte_valid(byte_valid), .rd_ready(rd_ready), .ovf(ovf)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    // Reference model: queue of buffered words, word in flight and which half is shown.
    logic [15:0] mq[$];
    logic [15:0] mhold;
    int          mphase;   // 0 none, 1 high byte shown, 2 low byte shown
    bit          movf;
    logic [7:0]  got_q[$];

    typedef struct {
        logic        wr;
        logic [15:0] data;
        logic        rd;
        logic        exp_valid;
        logic [7:0]  exp_byte;
        int          exp_level;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input int got, input int exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic model_reset();
        mq.delete();
        mhold  = '0;
        mphase = 0;
        movf   = 1'b0;
    endtask

    task automatic model_step(input logic wr, input logic [15:0] data, input logic rd);
        bit full;
        bit take;
        full = (mq.size() == DEPTH);
        take = (mq.size() > 0) && (mphase == 0 || (mphase == 2 && rd));
`ifdef WORD_UNPACKER_OVF_EN
        if (wr && full) movf = 1'b1;
`endif
        if (take) mhold = mq.pop_front();
        if (mphase == 0)      mphase = take ? 1 : 0;
        else if (mphase == 1) mphase = rd ? 2 : 1;
        else if (rd)          mphase = take ? 1 : 0;
        if (wr && !full) mq.push_back(data);
    endtask

    function automatic int model_byte();
        if (mphase == 1) return int'(mhold[15:8]);
        if (mphase == 2) return int'(mhold[7:0]);
        return 0;
    endfunction

    task automatic tick();
        if (byte_valid && rd_ready) got_q.push_back(byte_out);
        @(posedge clk);
        model_step(wr_en, wr_data, rd_ready);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n    = 1'b0;
        wr_en    = 1'b0;
        wr_data  = '0;
        rd_ready = 1'b0;
        #2;
        chk("rst_valid", byte_valid, 0);
        chk("rst_byte", byte_out, 0);
        chk("rst_level", level, 0);
        chk("rst_full", wr_full, 0);
        chk("rst_ovf", ovf, 0);
        model_reset();
        got_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic int exp_ovf_after_drop();
`ifdef WORD_UNPACKER_OVF_EN
        return 1;
`else
        return 0;
`endif
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] words[$];
        logic [7:0]  expb[$];
        logic        rdpat[5];
        int          bytepat[5];

        // Single word, then three back-to-back words with rd_ready held high.
        vecs[0]  = '{1'b1, 16'hA55A, 1'b1, 1'b0, 8'h00, 1};
        vecs[1]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 8'hA5, 0};
        vecs[2]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 8'h5A, 0};
        vecs[3]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 8'h00, 0};
        vecs[4]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 8'h00, 0};
        vecs[5]  = '{1'b1, 16'h1122, 1'b1, 1'b0, 8'h00, 1};
        vecs[6]  = '{1'b1, 16'h3344, 1'b1, 1'b1, 8'h11, 1};
        vecs[7]  = '{1'b1, 16'h5566, 1'b1, 1'b1, 8'h22, 2};
        vecs[8]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 8'h33, 1};
        vecs[9]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 8'h44, 1};
        vecs[10] = '{1'b0, 16'h0000, 1'b1, 1'b1, 8'h55, 0};
        vecs[11] = '{1'b0, 16'h0000, 1'b1, 1'b1, 8'h66, 0};
        vecs[12] = '{1'b0, 16'h0000, 1'b1, 1'b0, 8'h00, 0};

        do_reset();
        for (int i = 0; i < 13; i++) begin
            wr_en    = vecs[i].wr;
            wr_data  = vecs[i].data;
            rd_ready = vecs[i].rd;
            tick();
            chk($sformatf("vec%0d_valid", i), byte_valid, vecs[i].exp_valid);
            chk($sformatf("vec%0d_byte", i), byte_out, vecs[i].exp_byte);
            chk($sformatf("vec%0d_level", i), level, vecs[i].exp_level);
            chk($sformatf("vec%0d_full", i), wr_full, int'(vecs[i].exp_level == DEPTH));
        end

        // Fill with rd_ready low; the sixth write must be dropped.
        do_reset();
        words.delete();
        for (int k = 0; k < 5; k++) begin
            wr_en   = 1'b1;
            wr_data = 16'(16'h1000 + k * 16'h0111);
            words.push_back(wr_data);
            tick();
        end
        chk("fill_level", level, DEPTH);
        chk("fill_full", wr_full, 1);
        chk("fill_valid", byte_valid, 1);
        chk("fill_byte", byte_out, 8'h10);
        chk("fill_ovf_before", ovf, 0);
        wr_data = 16'hDEAD;
        tick();
        chk("drop_level", level, DEPTH);
        chk("drop_ovf", ovf, exp_ovf_after_drop());
        wr_en    = 1'b0;
        rd_ready = 1'b1;
        got_q.delete();
        repeat (14) tick();
        chk("drain_count", got_q.size(), 10);
        for (int k = 0; k < 10 && k < got_q.size(); k++) begin
            chk($sformatf("drain_byte%0d", k), got_q[k],
                (k % 2 == 0) ? int'(words[k/2][15:8]) : int'(words[k/2][7:0]));
        end
        chk("drain_valid", byte_valid, 0);
        chk("drain_level", level, 0);
        chk("drain_ovf_sticky", ovf, exp_ovf_after_drop());

        // Backpressure on both halves of one word.
        do_reset();
        wr_en   = 1'b1;
        wr_data = 16'hBEEF;
        tick();
        wr_en = 1'b0;
        tick();
        chk("bp_first_valid", byte_valid, 1);
        chk("bp_first_byte", byte_out, 8'hBE);
        rdpat   = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        bytepat = '{8'hBE, 8'hEF, 8'hEF, 8'hEF, -1};
        for (int k = 0; k < 5; k++) begin
            rd_ready = rdpat[k];
            tick();
            chk($sformatf("bp%0d_valid", k), byte_valid, int'(bytepat[k] >= 0));
            chk($sformatf("bp%0d_byte", k), byte_out, (bytepat[k] >= 0) ? bytepat[k] : 0);
        end

        // Asynchronous reset while showing the low byte with two words queued.
        do_reset();
        for (int k = 0; k < 3; k++) begin
            wr_en   = 1'b1;
            wr_data = 16'(16'hC0C1 + k * 16'h0202);
            tick();
        end
        wr_en    = 1'b0;
        rd_ready = 1'b1;
        tick();
        chk("mid_level", level, 2);
        chk("mid_byte", byte_out, 8'hC1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_valid", byte_valid, 0);
        chk("async_level", level, 0);
        chk("async_byte", byte_out, 0);
        chk("async_full", wr_full, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        got_q.delete();
        for (int k = 0; k < 6; k++) begin
            tick();
            chk($sformatf("post_rst_valid%0d", k), byte_valid, 0);
        end
        chk("post_rst_bytes", got_q.size(), 0);

        // Words straddling the pointer wrap keep their order.
        do_reset();
        words = '{16'hA1A2, 16'hB1B2, 16'hC1C2, 16'hD1D2, 16'h0102, 16'h0304};
        rd_ready = 1'b1;
        foreach (words[k]) begin
            wr_en   = 1'b1;
            wr_data = words[k];
            tick();
        end
        wr_en = 1'b0;
        repeat (20) tick();
        expb.delete();
        foreach (words[k]) begin
            expb.push_back(words[k][15:8]);
            expb.push_back(words[k][7:0]);
        end
        chk("wrap_count", got_q.size(), expb.size());
        for (int k = 0; k < expb.size() && k < got_q.size(); k++)
            chk($sformatf("wrap_byte%0d", k), got_q[k], expb[k]);

        // Random traffic against the reference model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            wr_en    = ($urandom_range(0, 9) < 6);
            wr_data  = 16'($urandom);
            rd_ready = (c < 1500) ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 9) < 8);
            tick();
            chk("rnd_valid", byte_valid, int'(mphase != 0));
            chk("rnd_byte", byte_out, model_byte());
            chk("rnd_level", level, mq.size());
            chk("rnd_full", wr_full, int'(mq.size() == DEPTH));
            chk("rnd_ovf", ovf, int'(movf));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
